// File: rtl/wb_slave_pkg.sv
`default_nettype none
// ============================================================================
// wb_slave_pkg
// Shared types and constants for the Wishbone responder memory.
// Revision: 1.0
// ============================================================================
package wb_slave_pkg;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int SEL_WIDTH      = BUS_DATA_WIDTH / 8;
  localparam int ADDR_LSB       = 2;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rggen_wishbone_if.sv
`default_nettype none
// ============================================================================
// rggen_wishbone_if
// Wishbone classic bus bundle with master and slave views.
// Revision: 1.0
// ============================================================================
interface rggen_wishbone_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      stall;
  logic [ADDRESS_WIDTH-1:0]  adr;
  logic                      we;
  logic [DATA_WIDTH-1:0]     dat_w;
  logic [DATA_WIDTH/8-1:0]   sel;
  logic                      ack;
  logic                      err;
  logic                      rty;
  logic [DATA_WIDTH-1:0]     dat_r;

  modport master (
    output cyc, stb, adr, we, dat_w, sel,
    input  stall, ack, err, rty, dat_r
  );

  modport slave (
    input  cyc, stb, adr, we, dat_w, sel,
    output stall, ack, err, rty, dat_r
  );
endinterface
`default_nettype wire

// File: rtl/wb_slave_bytemem.sv
`default_nettype none
// ============================================================================
// wb_slave_bytemem
// Single-port word RAM, per-byte write enables, registered read, no reset.
// Revision: 1.0
// ============================================================================
module wb_slave_bytemem #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
  input  logic                    i_clk,
  input  logic [IDX_WIDTH-1:0]    i_addr,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read-before-write: a read in the same cycle as a write returns old data.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (i_be[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/wishbone_slave_memory.sv
`default_nettype none
// ============================================================================
// wishbone_slave_memory
// Wishbone classic responder over a byte-lane RAM with fixed wait states,
// error response for illegal addresses and saturating ack/err counters.
// Revision: 1.0
// ============================================================================
module wishbone_slave_memory
  import wb_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rggen_wishbone_if.slave      wb_if,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_access_count,
  output logic [CNT_WIDTH-1:0] o_err_count
);

  localparam int                    c_idx_w     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]            c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH-1:0] c_depth     = ADDR_WIDTH'(DEPTH_WORDS);

  state_e                r_state;
  logic [3:0]            r_wait_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_dat_w;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_ack;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_access_cnt;
  logic [CNT_WIDTH-1:0]  r_err_cnt;

  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_cur_adr;
  logic                  w_cur_we;
  logic [DATA_WIDTH-1:0] w_cur_dat;
  logic [SEL_WIDTH-1:0]  w_cur_sel;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_cur_legal;
  logic                  w_go_resp;
  logic [SEL_WIDTH-1:0]  w_be;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_req = wb_if.cyc && wb_if.stb;

  // With zero wait states the request is latched on the same edge that enters
  // RESP, so the bus itself stands in for the latched copy while IDLE.
  always_comb begin
    if (r_state == IDLE) begin
      w_cur_adr = wb_if.adr;
      w_cur_we  = wb_if.we;
      w_cur_dat = wb_if.dat_w;
      w_cur_sel = wb_if.sel;
    end else begin
      w_cur_adr = r_adr;
      w_cur_we  = r_we;
      w_cur_dat = r_dat_w;
      w_cur_sel = r_sel;
    end
  end

  assign w_offset    = w_cur_adr - BASE_ADDR;
  assign w_word_idx  = w_offset >> ADDR_LSB;
  assign w_cur_legal = (w_cur_adr[ADDR_LSB-1:0] == '0) &&
                       (w_cur_adr >= BASE_ADDR) &&
                       (w_word_idx < c_depth);

  assign w_go_resp = ((r_state == IDLE) && w_req && (WAIT_CYCLES == 0)) ||
                     ((r_state == WAIT) && wb_if.cyc && (r_wait_cnt == 4'd0));

  assign w_be = (w_go_resp && w_cur_legal && w_cur_we) ? w_cur_sel : '0;

  wb_slave_bytemem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_WIDTH   (c_idx_w)
  ) u_mem (
    .i_clk   (i_clk),
    .i_addr  (w_word_idx[c_idx_w-1:0]),
    .i_be    (w_be),
    .i_wdata (w_cur_dat),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 4'd0;
      r_adr        <= '0;
      r_we         <= 1'b0;
      r_dat_w      <= '0;
      r_sel        <= '0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
      r_access_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_adr      <= wb_if.adr;
            r_we       <= wb_if.we;
            r_dat_w    <= wb_if.dat_w;
            r_sel      <= wb_if.sel;
            r_wait_cnt <= c_wait_load;
            r_state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!wb_if.cyc) begin
            r_state <= IDLE;
          end else if (r_wait_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_go_resp) begin
        r_ack <= w_cur_legal;
        r_err <= !w_cur_legal;
        if (w_cur_legal) begin
          r_access_cnt <= sat_inc(r_access_cnt);
        end else begin
          r_err_cnt <= sat_inc(r_err_cnt);
        end
      end
    end
  end

  // Read data is gated by registered qualifiers only; it never sees the bus.
  assign wb_if.dat_r = (r_ack && !r_we) ? w_rdata : '0;
  assign wb_if.ack   = r_ack;
  assign wb_if.err   = r_err;
  assign wb_if.stall = 1'b0;
  assign wb_if.rty   = 1'b0;

  assign o_busy         = (r_state == WAIT) || (r_state == RESP);
  assign o_access_count = r_access_cnt;
  assign o_err_count    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_slave_memory.sv
`default_nettype none
// ============================================================================
// tb_wishbone_slave_memory
// Three responders (1, 3 and 0 wait states) against a word-array model.
// Revision: 1.0
// ============================================================================
module tb_wishbone_slave_memory;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk;
  logic        rst_n  [3];
  logic        m_cyc  [3];
  logic        m_stb  [3];
  logic        m_we   [3];
  logic [31:0] m_adr  [3];
  logic [31:0] m_dat  [3];
  logic [3:0]  m_sel  [3];
  logic        s_ack  [3];
  logic        s_err  [3];
  logic        s_stall[3];
  logic        s_rty  [3];
  logic [31:0] s_dat  [3];
  logic        s_busy [3];
  logic [15:0] s_acc  [3];
  logic [15:0] s_errc [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    rggen_wishbone_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.cyc   = m_cyc[k];
    assign bus.stb   = m_stb[k];
    assign bus.we    = m_we[k];
    assign bus.adr   = m_adr[k];
    assign bus.dat_w = m_dat[k];
    assign bus.sel   = m_sel[k];
    assign s_ack[k]   = bus.ack;
    assign s_err[k]   = bus.err;
    assign s_stall[k] = bus.stall;
    assign s_rty[k]   = bus.rty;
    assign s_dat[k]   = bus.dat_r;

    wishbone_slave_memory #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (32),
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .WAIT_CYCLES (k == 0 ? 1 : (k == 1 ? 3 : 0))
    ) u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n[k]),
      .wb_if          (bus),
      .o_busy         (s_busy[k]),
      .o_access_count (s_acc[k]),
      .o_err_count    (s_errc[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word array plus per-byte "has been written" flags.
  logic [31:0] mem     [3][DEPTH];
  logic [3:0]  known   [3][DEPTH];
  int          exp_acc [3];
  int          exp_err [3];
  bit          pend    [3];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] rand_addr(input int kind);
    logic [31:0] a;
    case (kind)
      3:       a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      4:       a = BASE - 4 * $urandom_range(1, 16);
      5:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 16);
      default: a = BASE + 4 * $urandom_range(0, DEPTH - 1);
    endcase
    return a;
  endfunction

  // One transfer. Called just after a rising edge. With keep=1 the request
  // lines stay asserted after the response, so the next call is back-to-back.
  task automatic xfer(input int k, input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input bit keep);
    int          lat;
    int          exp_lat;
    int          idx;
    bit          resp;
    bit          legal;
    logic [31:0] mask;
    legal   = (adr % 4 == 0) && (adr >= BASE) && ((adr - BASE) / 4 < DEPTH);
    idx     = legal ? int'((adr - BASE) / 4) : 0;
    exp_lat = wc(k) + 1 + (pend[k] ? 1 : 0);
    m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = we;
    m_adr[k] = adr;  m_dat[k] = dat;  m_sel[k] = sel;
    lat  = 0;
    resp = 1'b0;
    while (!resp && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (s_ack[k] || s_err[k]) resp = 1'b1;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (resp) begin
      chk("ack", 32'(s_ack[k]), 32'(legal));
      chk("err", 32'(s_err[k]), 32'(!legal));
      chk("busy_resp", 32'(s_busy[k]), 32'd1);
      if (legal && !we) begin
        mask = '0;
        for (int i = 0; i < 4; i++) if (known[k][idx][i]) mask[8*i +: 8] = 8'hFF;
        chk("rdata", s_dat[k] & mask, mem[k][idx] & mask);
      end else if (!legal) begin
        chk("err_rdata", s_dat[k], 32'd0);
      end
      if (legal && we) begin
        for (int i = 0; i < 4; i++) begin
          if (sel[i]) begin
            mem[k][idx][8*i +: 8] = dat[8*i +: 8];
            known[k][idx][i] = 1'b1;
          end
        end
      end
      if (legal) exp_acc[k] = (exp_acc[k] < 65535) ? exp_acc[k] + 1 : 65535;
      else       exp_err[k] = (exp_err[k] < 65535) ? exp_err[k] + 1 : 65535;
      chk("acc_cnt", 32'(s_acc[k]), 32'(exp_acc[k]));
      chk("err_cnt", 32'(s_errc[k]), 32'(exp_err[k]));
    end
    pend[k] = keep && resp;
    if (!pend[k]) begin
      m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
      @(posedge clk); #1;
      chk("no_dup_resp", 32'({s_ack[k], s_err[k]}), 32'd0);
      chk("idle_busy", 32'(s_busy[k]), 32'd0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; m_cyc[k] = 1'b0; m_stb[k] = 1'b0; m_we[k] = 1'b0;
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = '0;
      exp_acc[k] = 0; exp_err[k] = 0; pend[k] = 1'b0;
      for (int w = 0; w < DEPTH; w++) begin
        mem[k][w] = '0; known[k][w] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", 32'(s_ack[k]), 32'd0);
      chk("rst_err", 32'(s_err[k]), 32'd0);
      chk("rst_busy", 32'(s_busy[k]), 32'd0);
      chk("rst_dat", s_dat[k], 32'd0);
      chk("rst_acc", 32'(s_acc[k]), 32'd0);
      chk("rst_errc", 32'(s_errc[k]), 32'd0);
      chk("tied_stall_rty", 32'({s_stall[k], s_rty[k]}), 32'd0);
      rst_n[k] = 1'b1;
    end
    @(posedge clk); #1;

    // One wait state: basic write/read, byte lanes, illegal accesses.
    xfer(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    xfer(0, 1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0);
    chk("acc_after_two", 32'(s_acc[0]), 32'd2);
    xfer(0, 1'b1, BASE + 32'h20, 32'h11223344, 4'hF, 1'b0);
    xfer(0, 1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    xfer(0, 1'b0, BASE + 32'h20, 32'h0, 4'hF, 1'b0);
    chk("lane_model", mem[0][8], 32'h11BB33DD);
    xfer(0, 1'b1, BASE, 32'h01234567, 4'hF, 1'b0);
    xfer(0, 1'b1, BASE + 32'h24, 32'h5A5A5A5A, 4'hF, 1'b0);
    xfer(0, 1'b1, BASE + 32'h24, 32'hFFFFFFFF, 4'h0, 1'b0);
    xfer(0, 1'b0, BASE + 32'h24, 32'h0, 4'hF, 1'b0);
    xfer(0, 1'b0, BASE + 32'h13, 32'h0, 4'hF, 1'b0);
    xfer(0, 1'b1, BASE + 4 * DEPTH, 32'hFEEDFACE, 4'hF, 1'b0);
    chk("errc_after_two", 32'(s_errc[0]), 32'd2);
    xfer(0, 1'b1, BASE - 32'd4, 32'hFEEDFACE, 4'hF, 1'b0);
    xfer(0, 1'b0, BASE, 32'h0, 4'hF, 1'b0);

    // Three wait states: abort during WAIT, then reset during WAIT.
    xfer(1, 1'b1, BASE + 32'h40, 32'h55AA55AA, 4'hF, 1'b0);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1] = BASE + 32'h40; m_dat[1] = 32'hCAFEF00D; m_sel[1] = 4'hF;
    @(posedge clk); #1;
    chk("abort_busy", 32'(s_busy[1]), 32'd1);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 32'({s_ack[1], s_err[1]}), 32'd0);
    end
    chk("abort_idle", 32'(s_busy[1]), 32'd0);
    chk("abort_acc", 32'(s_acc[1]), 32'(exp_acc[1]));
    xfer(1, 1'b0, BASE + 32'h40, 32'h0, 4'hF, 1'b0);

    xfer(1, 1'b1, BASE + 32'h44, 32'h0BADF00D, 4'hF, 1'b0);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1] = BASE + 32'h44; m_dat[1] = 32'h12345678; m_sel[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(s_busy[1]), 32'd1);
    rst_n[1] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1;
    chk("mid_rst_ack_err", 32'({s_ack[1], s_err[1]}), 32'd0);
    chk("mid_rst_busy", 32'(s_busy[1]), 32'd0);
    chk("mid_rst_acc", 32'(s_acc[1]), 32'd0);
    chk("mid_rst_errc", 32'(s_errc[1]), 32'd0);
    exp_acc[1] = 0; exp_err[1] = 0; pend[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, BASE + 32'h44, 32'h0, 4'hF, 1'b0);

    // Zero wait states: 20 back-to-back legal transfers.
    for (int n = 0; n < 20; n++) begin
      xfer(2, bit'($urandom_range(0, 1)), rand_addr(0), $urandom, 4'($urandom), n != 19);
    end
    chk("b2b_count", 32'(s_acc[2]), 32'd20);

    // Randomized mix of legal/illegal, reads/writes, isolated/back-to-back.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 25; n++) begin
        xfer(k, bit'($urandom_range(0, 1)), rand_addr(int'($urandom_range(0, 5))),
             $urandom, 4'($urandom), (n != 24) && ($urandom_range(0, 1) == 1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
